// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port arbiter in front of a shared, external combinational ALU.
// A request is latched into registered ALU drive, the ALU result is captured one
// cycle later, and the result is then held for the owning requester until it
// consumes it.
// Optional feature macro: ALU_ARB_ILLEGAL_CHK_EN adds rsp0_err/rsp1_err and
// flags ALUFun codes outside the legal set (their result is forced to 0).
//
// Handshakes: a request transfers on a cycle where reqN_valid && reqN_ready;
// a response transfers on a cycle where rspN_valid && rspN_ready. valid may be
// dropped freely while ready is low, and only the owner's rspN_ready is honoured.
module alu_arbiter #(
    parameter int unsigned PRIO_INIT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [5:0]  req0_fun,
    input  logic        req0_sign,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [5:0]  req1_fun,
    input  logic        req1_sign,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
`ifdef ALU_ARB_ILLEGAL_CHK_EN
    output logic        rsp0_err,
    output logic        rsp1_err,
`endif
    output logic [31:0] rsp_s,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [5:0]  alu_fun,
    output logic        alu_sign,
    input  logic [31:0] alu_s,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // last_grant resets to the opposite of PRIO_INIT so PRIO_INIT wins first
    localparam logic LAST_GRANT_RST = ~PRIO_INIT[0];

    state_t      state_q;
    state_t      state_d;
    logic        last_grant_q;
    logic        owner_q;
    logic        sel;
    logic        accept;
    logic [31:0] result_q;
    logic        owner_ready;
    logic        illegal_q;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    function automatic logic fun_legal(input logic [5:0] f);
        case (f)
            6'b000000, 6'b000001, 6'b011000, 6'b011110,
            6'b010110, 6'b010001, 6'b011010, 6'b100000,
            6'b100001, 6'b100011, 6'b110011, 6'b110001,
            6'b110101, 6'b111101, 6'b111011, 6'b111111: fun_legal = 1'b1;
            default:                                     fun_legal = 1'b0;
        endcase
    endfunction
`endif

    // Requester selection: a lone valid requester wins, otherwise alternate
    always_comb begin
        sel = ~last_grant_q;
        if (req0_valid ^ req1_valid) begin
            sel = req1_valid;
        end
    end

    assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;

    // Next-state and handshake outputs
    always_comb begin
        state_d    = state_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                req0_ready = !reset && (sel == 1'b0);
                req1_ready = !reset && (sel == 1'b1);
                accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
                if (accept) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
            end
            RESP: begin
                rsp0_valid = (owner_q == 1'b0);
                rsp1_valid = (owner_q == 1'b1);
                if (owner_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch on accept, result capture in EXEC
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a        <= '0;
            alu_b        <= '0;
            alu_fun      <= '0;
            alu_sign     <= 1'b0;
            result_q     <= '0;
            owner_q      <= 1'b0;
            last_grant_q <= LAST_GRANT_RST;
            illegal_q    <= 1'b0;
        end else begin
            if (accept) begin
                alu_a        <= sel ? req1_a    : req0_a;
                alu_b        <= sel ? req1_b    : req0_b;
                alu_fun      <= sel ? req1_fun  : req0_fun;
                alu_sign     <= sel ? req1_sign : req0_sign;
                owner_q      <= sel;
                last_grant_q <= sel;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
                illegal_q    <= !fun_legal(sel ? req1_fun : req0_fun);
`else
                illegal_q    <= 1'b0;
`endif
            end
            if (state_q == EXEC) begin
                result_q <= illegal_q ? 32'd0 : alu_s;
            end
        end
    end

`ifdef ALU_ARB_ILLEGAL_CHK_EN
    assign rsp0_err = rsp0_valid && illegal_q;
    assign rsp1_err = rsp1_valid && illegal_q;
`endif

    assign rsp_s     = result_q;
    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: PRIO_INIT, default 0, index of the requester that wins the first two-way contention after reset.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 reqN_valid  in  1  (N = 0,1) requester N presents an operation.
REQ-005 reqN_ready  out  1  operation of requester N accepted this cycle.
REQ-006 reqN_a, reqN_b  in  32  operands A and B (A[4:0] is the shift amount for shift codes).
REQ-007 reqN_fun  in  6  ALUFun code; reqN_sign  in  1  signed-compare select.
REQ-008 rspN_valid  out  1  result for requester N available.
REQ-009 rspN_ready  in  1  requester N consumes the result.
REQ-010 rsp_s  out  32  result data, shared by both response ports.
REQ-011 alu_a, alu_b  out  32; alu_fun  out  6; alu_sign  out  1  registered drive to the shared ALU.
REQ-012 alu_s  in  32  combinational ALU result.
REQ-013 busy  out  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, EXEC, RESP.
REQ-015 In IDLE the selected requester sel is the only valid one if exactly one reqN_valid is high, otherwise the requester not equal to last_grant.
REQ-016 reqN_ready = (state==IDLE) && (sel==N); at most one ready is high per cycle.
REQ-017 Accept (reqN_valid && reqN_ready): latch a/b/fun/sign into alu_* registers, record owner=N, last_grant=N, go to EXEC.
REQ-018 EXEC lasts exactly one cycle: capture alu_s into the result register, go to RESP.
REQ-019 RESP: rsp_owner_valid=1, the other rsp valid=0, rsp_s=result register; stay until rsp_owner_ready, then go to IDLE.
REQ-020 Latency: accept in cycle t means rspN_valid is high from cycle t+2; minimum issue interval is 3 cycles, with no acceptance in EXEC or RESP.
REQ-021 alu_*, rsp_s and the result register hold their values outside load cycles; requester inputs are sampled only on accept.
REQ-022 A response ignores rspN_ready of the non-owner.
REQ-023 Under continuous contention from both requesters, grants strictly alternate.
REQ-024 A requester dropping valid while not ready has no effect.

Reset
REQ-025 Reset forces state=IDLE, all rspN_valid=0, busy=0, alu_a/alu_b/rsp_s/result=0, alu_fun=0, alu_sign=0, last_grant=~PRIO_INIT.
REQ-026 Reset during EXEC or RESP aborts the operation; no response is issued for it.
REQ-027 reqN_ready is 0 in any cycle where reset is high.

Configuration
REQ-028 Macro ALU_ARB_ILLEGAL_CHK_EN.
REQ-029 When the macro is defined, ports rspN_err (out, 1) exist and the legal fun set is 000000, 000001, 011000, 011110, 010110, 010001, 011010, 100000, 100001, 100011, 110011, 110001, 110101, 111101, 111011, 111111.
REQ-030 When defined, an illegal fun is still accepted with normal timing, the result register loads 0 instead of alu_s, and rsp_owner_err=1 during RESP; rspN_err is otherwise 0.
REQ-031 When the macro is undefined, the rspN_err ports are absent and every fun code is passed to the ALU unchanged.

Verification
REQ-032 req0 only, a=12345, b=54321, fun=000000 -> req0_ready at accept, rsp0_valid 2 cycles later, rsp_s=66666.
REQ-033 req0 and req1 valid together after reset, PRIO_INIT=0, req0 fun=000001 (12345,54321), req1 fun=011000 (12345,54321) -> req0 served first with rsp_s=0xFFFF5C08, then req1 with rsp_s=4145; then req0 again if both stay valid.
REQ-034 req1 a=4, b=54321, fun=100000, rsp1_ready held low for 5 cycles -> rsp1_valid and rsp_s=869136 stable throughout, busy=1, req0_ready=0; IDLE one cycle after rsp1_ready.
REQ-035 req0 fun=110101, sign=1, a=12345, b=54321 -> rsp_s=1; fun=110011 with the same operands -> rsp_s=0.
REQ-036 Reset asserted in the RESP cycle of a req0 operation -> next cycle rsp0_valid=0, busy=0, alu_*=0; no late response.
REQ-037 With ALU_ARB_ILLEGAL_CHK_EN defined, req0 fun=000111 -> rsp0_err=1, rsp_s=0; with the macro undefined, alu_fun=000111 is driven.
